// File: rtl/sap1_program_loader.sv
// Program-mode loader for the SAP-1 core. It streams DEPTH bytes into program RAM,
// issuing one MAR load and one RAM write per byte, then releases the core to run mode.
module sap1_program_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] Wbus_ext,
   output logic              nLm_ext,
   output logic              ram_sel,
   output logic              nwr,
   output logic              prog,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] load_addr,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] sum_d;
   logic [DATA_W-1:0] wbus_d;

   always_ff @(posedge CLK) begin
      if (!CLR) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = load_addr;
      sum_d   = checksum;
      wbus_d  = Wbus_ext;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = ADDR;
               addr_d  = '0;
               sum_d   = '0;
            end
         end
         ADDR: state_d = DATA;
         DATA: begin
            if (in_valid && in_ready) begin
               state_d = WRITE;
               wbus_d  = in_data;
               sum_d   = checksum + in_data;
            end
         end
         WRITE: begin
            if (load_addr == LAST) state_d = DONE;
            else begin
               addr_d  = load_addr + 1'b1;
               state_d = ADDR;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == ADDR) wbus_d = DATA_W'(addr_d);
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         Wbus_ext  <= '0;
         nLm_ext   <= 1'b1;
         ram_sel   <= 1'b1;
         nwr       <= 1'b1;
         in_ready  <= 1'b0;
         prog      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         load_addr <= '0;
         checksum  <= '0;
      end else begin
         Wbus_ext  <= wbus_d;
         nLm_ext   <= (state_d != ADDR);
         ram_sel   <= (state_d != WRITE);
         nwr       <= (state_d != WRITE);
         in_ready  <= (state_d == DATA);
         prog      <= (state_d == DONE);
         busy      <= (state_d == ADDR) || (state_d == DATA) || (state_d == WRITE);
         done      <= (state_d == DONE);
         load_addr <= addr_d;
         checksum  <= sum_d;
      end
   end

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed bench for sap1_program_loader with a behavioural MAR/RAM model on the
// programming port and a protocol monitor on the strobes.
module tb_sap1_program_loader;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, nLm_ext, ram_sel, nwr, prog, busy, done;
   logic [7:0] Wbus_ext, checksum;
   logic [3:0] load_addr;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ram [16];
   logic [3:0] mar;
   logic [7:0] src [16];
   int viol = 0, wr_cnt = 0, busy_cnt = 0, prog_viol = 0;

   sap1_program_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
      .CLK(CLK), .CLR(CLR), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .Wbus_ext(Wbus_ext), .nLm_ext(nLm_ext), .ram_sel(ram_sel),
      .nwr(nwr), .prog(prog), .busy(busy), .done(done), .load_addr(load_addr),
      .checksum(checksum)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (!nLm_ext) mar <= Wbus_ext[3:0];
      if (!ram_sel && !nwr) ram[mar] <= Wbus_ext;
   end

   always @(negedge CLK) begin
      if (!nLm_ext && !nwr) viol++;
      if (!ram_sel && nwr) viol++;
      if (!nwr) wr_cnt++;
      if (busy) busy_cnt++;
      if (busy && prog) prog_viol++;
   end

   task automatic pulse_start();
      @(negedge CLK); start = 1'b1;
      @(negedge CLK); start = 1'b0;
   endtask

   // Feeds src[0..n-1]; optionally withholds in_valid for stall_len DATA cycles at
   // byte stall_k and pulses start while busy at byte start_k.
   task automatic feed(input int n, input int stall_k, input int stall_len, input int start_k);
      int k = 0, cyc = 0, left = stall_len;
      bit acc, pulsed = 0;
      while (k < n && cyc < 400) begin
         @(negedge CLK); cyc++;
         in_data = src[k];
         start = (k == start_k && !pulsed);
         if (start) pulsed = 1;
         if (k == stall_k && left > 0 && in_ready) begin
            in_valid = 1'b0;
            n_cmp++;
            if (in_ready !== 1'b1 || nLm_ext !== 1'b1 || nwr !== 1'b1 || ram_sel !== 1'b1) begin
               $display("FAIL stall_idle: ready=%b nLm=%b nwr=%b sel=%b, want 1 1 1 1",
                        in_ready, nLm_ext, nwr, ram_sel);
               n_err++;
            end
            left--;
         end else in_valid = 1'b1;
         acc = in_ready && in_valid;
         @(posedge CLK);
         if (acc) begin
            @(negedge CLK); start = 1'b0;
            n_cmp++;
            if (nwr !== 1'b0 || ram_sel !== 1'b0 || Wbus_ext !== src[k]) begin
               $display("FAIL write_%0d: nwr=%b sel=%b bus=%h, want 0 0 %h",
                        k, nwr, ram_sel, Wbus_ext, src[k]);
               n_err++;
            end
            k++;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (k != n) begin
         $display("FAIL feed_timeout: accepted %0d, want %0d", k, n);
         n_err++;
      end
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (done !== 1'b1 && cyc < 50) begin @(negedge CLK); cyc++; end
      n_cmp++;
      if (done !== 1'b1) begin
         $display("FAIL done_timeout: done=%b, want 1", done);
         n_err++;
      end
   endtask

   task automatic test_reset();
      CLR = 1'b0;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({Wbus_ext, nLm_ext, ram_sel, nwr, in_ready, prog, busy, done} !== {8'h00, 7'b1110000}) begin
         $display("FAIL reset_outs: bus=%h nLm=%b sel=%b nwr=%b rdy=%b prog=%b busy=%b done=%b",
                  Wbus_ext, nLm_ext, ram_sel, nwr, in_ready, prog, busy, done);
         n_err++;
      end
      n_cmp++;
      if (load_addr !== 4'h0 || checksum !== 8'h00) begin
         $display("FAIL reset_regs: addr=%h sum=%h, want 0 00", load_addr, checksum);
         n_err++;
      end
      CLR = 1'b1;
      in_valid = 1'b1;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || wr_cnt != 0) begin
         $display("FAIL idle_ignores_valid: busy=%b rdy=%b writes=%0d, want 0 0 0",
                  busy, in_ready, wr_cnt);
         n_err++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_load();
      for (int i = 0; i < 16; i++) src[i] = 8'(i);
      busy_cnt = 0; wr_cnt = 0;
      pulse_start();
      n_cmp++;
      if (nLm_ext !== 1'b0 || Wbus_ext !== 8'h00 || busy !== 1'b1) begin
         $display("FAIL first_addr: nLm=%b bus=%h busy=%b, want 0 00 1", nLm_ext, Wbus_ext, busy);
         n_err++;
      end
      feed(16, -1, 0, -1);
      wait_done();
      n_cmp++;
      if (checksum !== 8'h78 || prog !== 1'b1 || busy !== 1'b0 || load_addr !== 4'hF) begin
         $display("FAIL full_done: sum=%h prog=%b busy=%b addr=%h, want 78 1 0 f",
                  checksum, prog, busy, load_addr);
         n_err++;
      end
      n_cmp++;
      if (busy_cnt != 48 || wr_cnt != 16) begin
         $display("FAIL full_cycles: busy=%0d writes=%0d, want 48 16", busy_cnt, wr_cnt);
         n_err++;
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (ram[i] !== 8'(i)) begin
            $display("FAIL ram_%0d: got %h, want %h", i, ram[i], 8'(i));
            n_err++;
         end
      end
      in_valid = 1'b1;
      repeat (4) @(negedge CLK);
      n_cmp++;
      if (checksum !== 8'h78 || wr_cnt != 16 || done !== 1'b1) begin
         $display("FAIL done_hold: sum=%h writes=%0d done=%b, want 78 16 1", checksum, wr_cnt, done);
         n_err++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_restart();
      for (int i = 0; i < 16; i++) src[i] = 8'hFF;
      busy_cnt = 0; wr_cnt = 0; prog_viol = 0;
      pulse_start();
      n_cmp++;
      if (prog !== 1'b0 || done !== 1'b0 || nLm_ext !== 1'b0) begin
         $display("FAIL restart_enter: prog=%b done=%b nLm=%b, want 0 0 0", prog, done, nLm_ext);
         n_err++;
      end
      feed(16, -1, 0, 5);
      wait_done();
      n_cmp++;
      if (checksum !== 8'hF0 || prog_viol != 0) begin
         $display("FAIL restart_sum: sum=%h prog_hi=%0d, want f0 0", checksum, prog_viol);
         n_err++;
      end
      n_cmp++;
      if (busy_cnt != 48 || wr_cnt != 16) begin
         $display("FAIL start_ignored: busy=%0d writes=%0d, want 48 16", busy_cnt, wr_cnt);
         n_err++;
      end
      n_cmp++;
      if (ram[0] !== 8'hFF || ram[15] !== 8'hFF) begin
         $display("FAIL restart_ram: ram0=%h ram15=%h, want ff ff", ram[0], ram[15]);
         n_err++;
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 16; i++) src[i] = 8'(3 * i);
      busy_cnt = 0; wr_cnt = 0;
      pulse_start();
      feed(16, 3, 5, -1);
      wait_done();
      n_cmp++;
      if (checksum !== 8'h68 || busy_cnt != 53 || wr_cnt != 16) begin
         $display("FAIL backpressure: sum=%h busy=%0d writes=%0d, want 68 53 16",
                  checksum, busy_cnt, wr_cnt);
         n_err++;
      end
      n_cmp++;
      if (ram[3] !== 8'h09 || ram[15] !== 8'h2D) begin
         $display("FAIL bp_ram: ram3=%h ram15=%h, want 09 2d", ram[3], ram[15]);
         n_err++;
      end
   endtask

   task automatic test_reset_mid();
      int w0;
      for (int i = 0; i < 16; i++) src[i] = 8'hA0 + 8'(i);
      pulse_start();
      feed(7, -1, 0, -1);
      @(negedge CLK);
      CLR = 1'b0;
      w0 = wr_cnt;
      @(negedge CLK);
      CLR = 1'b1;
      in_valid = 1'b1;
      n_cmp++;
      if (busy !== 1'b0 || prog !== 1'b0 || load_addr !== 4'h0 || checksum !== 8'h00 || nLm_ext !== 1'b1) begin
         $display("FAIL mid_reset: busy=%b prog=%b addr=%h sum=%h nLm=%b, want 0 0 0 00 1",
                  busy, prog, load_addr, checksum, nLm_ext);
         n_err++;
      end
      repeat (10) @(negedge CLK);
      n_cmp++;
      if (wr_cnt != w0 || busy !== 1'b0) begin
         $display("FAIL mid_no_writes: writes=%0d busy=%b, want %0d 0", wr_cnt, busy, w0);
         n_err++;
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (ram[i] !== ((i < 7) ? 8'hA0 + 8'(i) : 8'h15)) begin
            $display("FAIL mid_ram_%0d: got %h", i, ram[i]);
            n_err++;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_restart();
      test_backpressure();
      test_reset_mid();
      n_cmp++;
      if (viol != 0) begin
         $display("FAIL strobe_overlap: violations=%0d, want 0", viol);
         n_err++;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
